// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: bus sizes, request direction
// and controller state encodings.
package mem_responder_pkg;

  localparam int unsigned LINE_WIDTH = 128;
  localparam int unsigned ADDR_SIZE  = 32;

  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } mem_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2,
    DROP = 2'd3
  } resp_state_t;

  // Counter width for a down-count from n-1 to 0; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Shared memory port between the arbiter (master) and the responder (slave).
interface mem_responder_if #(
  parameter int unsigned WIDTH  = 128,
  parameter int unsigned ADDR_W = 32
);

  logic              mem_enable;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_data_in;
  logic [WIDTH-1:0]  mem_data_out;
  logic              mem_ack;
  logic              mem_busy;

  modport master (
    output mem_enable, mem_rw, mem_addr, mem_data_in,
    input  mem_data_out, mem_ack, mem_busy
  );

  modport slave (
    input  mem_enable, mem_rw, mem_addr, mem_data_in,
    output mem_data_out, mem_ack, mem_busy
  );

endinterface

// File: rtl/mem_line_array.sv
// Single-port DEPTH x WIDTH line storage with registered read data; no reset,
// contents survive responder resets.
module mem_line_array #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] index,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Read-first: rdata shows the line as it was before a same-edge write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[index] <= wdata;
    end
    rdata <= mem[index];
  end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: captures one line request, completes it
// LATENCY edges later with a one-cycle mem_ack, then waits for enable to drop.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned WIDTH   = LINE_WIDTH,
  parameter int unsigned ADDR_W  = ADDR_SIZE,
  parameter int unsigned DEPTH   = 4096,
  parameter int unsigned LATENCY = 5
) (
  input  logic         clk,
  input  logic         reset,
  mem_responder_if.slave bus
);

  localparam int unsigned OFF_W = $clog2(WIDTH / 8);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = cnt_width(LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  resp_state_t      state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             ack_q, ack_next;
  mem_op_t          op_q;
  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] data_out_q;

  logic             capture;
  logic             commit;
  logic             arr_we;
  logic [IDX_W-1:0] req_idx;
  logic [IDX_W-1:0] arr_idx;
  logic [WIDTH-1:0] arr_rdata;
  logic             addr_unused;

  assign req_idx = bus.mem_addr[OFF_W +: IDX_W];
  // Byte-offset and upper address bits are intentionally don't-care.
  assign addr_unused = ^bus.mem_addr;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    ack_next   = 1'b0;
    capture    = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.mem_enable) begin
          capture    = 1'b1;
          cnt_next   = CNT_LOAD;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (cnt != '0) begin
          cnt_next = cnt - CNT_W'(1);
        end else begin
          commit     = 1'b1;
          ack_next   = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = bus.mem_enable ? DROP : IDLE;
      end
      DROP: begin
        if (!bus.mem_enable) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The array read is registered, so it is addressed by the incoming index
  // while idle; its rdata is then ready at the commit edge even for LATENCY=1.
  assign arr_idx = (state == IDLE) ? req_idx : idx_q;
  assign arr_we  = commit && (op_q == MEM_WRITE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      ack_q      <= 1'b0;
      op_q       <= MEM_READ;
      idx_q      <= '0;
      wdata_q    <= '0;
      data_out_q <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      ack_q <= ack_next;
      if (capture) begin
        op_q    <= mem_op_t'(bus.mem_rw);
        idx_q   <= req_idx;
        wdata_q <= bus.mem_data_in;
      end
      if (commit && (op_q == MEM_READ)) begin
        data_out_q <= arr_rdata;
      end
    end
  end

  mem_line_array #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .index (arr_idx),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

  assign bus.mem_ack      = ack_q;
  assign bus.mem_data_out = data_out_q;
  assign bus.mem_busy     = (state != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one 5-cycle-latency instance and one
// 1-cycle-latency instance sharing clock and reset.
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int unsigned W = 128;
  localparam logic [W-1:0] D_MAIN = 128'hDEADBEEF_00112233_44556677_8899AABB;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  mem_responder_if #(.WIDTH(W), .ADDR_W(32)) bus0 ();
  mem_responder_if #(.WIDTH(W), .ADDR_W(32)) bus1 ();

  mem_responder #(.WIDTH(W), .ADDR_W(32), .DEPTH(4096), .LATENCY(5)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );
  mem_responder #(.WIDTH(W), .ADDR_W(32), .DEPTH(4096), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit which, input logic en, input logic rw,
                       input logic [31:0] a, input logic [W-1:0] d);
    if (which) begin
      bus1.mem_enable = en; bus1.mem_rw = rw; bus1.mem_addr = a; bus1.mem_data_in = d;
    end else begin
      bus0.mem_enable = en; bus0.mem_rw = rw; bus0.mem_addr = a; bus0.mem_data_in = d;
    end
  endtask

  function automatic logic ack_of(input bit which);
    return which ? bus1.mem_ack : bus0.mem_ack;
  endfunction

  function automatic logic [W-1:0] dout_of(input bit which);
    return which ? bus1.mem_data_out : bus0.mem_data_out;
  endfunction

  // Issues one request, measures edges from capture to ack, then releases enable.
  task automatic do_req(input bit which, input logic rw, input logic [31:0] a,
                        input logic [W-1:0] d, output int lat,
                        output logic [W-1:0] rd, output int extra_acks);
    drive(which, 1'b1, rw, a, d);
    tick();
    lat = -1;
    rd  = '0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (ack_of(which) === 1'b1) begin
        lat = i;
        rd  = dout_of(which);
        break;
      end
    end
    drive(which, 1'b0, rw, a, d);
    extra_acks = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (ack_of(which) !== 1'b0) extra_acks++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, 1'b1, 1'b1, 32'h40, '1);
    drive(1, 1'b1, 1'b1, 32'h40, '1);
    #2 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (bus0.mem_ack !== 1'b0) begin bad++; $display("FAIL reset_ack: got %b want 0", bus0.mem_ack); end
      total++; if (bus0.mem_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus0.mem_busy); end
      total++; if (bus0.mem_data_out !== '0) begin bad++; $display("FAIL reset_dout: got %h want 0", bus0.mem_data_out); end
    end
    drive(0, 1'b0, 1'b0, 32'h0, '0);
    drive(1, 1'b0, 1'b0, 32'h0, '0);
    reset = 1'b1;
    tick();
    total++; if (bus0.mem_busy !== 1'b0) begin bad++; $display("FAIL reset_no_capture: got %b want 0", bus0.mem_busy); end
  endtask

  task automatic test_write_read();
    int lat, ex;
    logic [W-1:0] rd;
    do_req(0, MEM_WRITE, 32'h0000_0040, D_MAIN, lat, rd, ex);
    total++; if (lat != 5) begin bad++; $display("FAIL wr_latency: got %0d want 5", lat); end
    total++; if (ex != 0) begin bad++; $display("FAIL wr_single_pulse: got %0d extra acks want 0", ex); end
    total++; if (bus0.mem_data_out !== '0) begin bad++; $display("FAIL wr_dout_unchanged: got %h want 0", bus0.mem_data_out); end
    do_req(0, MEM_READ, 32'h0000_0040, '0, lat, rd, ex);
    total++; if (lat != 5) begin bad++; $display("FAIL rd_latency: got %0d want 5", lat); end
    total++; if (rd !== D_MAIN) begin bad++; $display("FAIL rd_data: got %h want %h", rd, D_MAIN); end
  endtask

  task automatic test_held_enable();
    int acks = 0;
    int busy_low = 0;
    int lat, ex;
    logic [W-1:0] rd;
    drive(0, 1'b1, MEM_WRITE, 32'h0000_0100, 128'h1234);
    tick();
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (bus0.mem_ack === 1'b1) acks++;
      if (i > 5 && bus0.mem_busy !== 1'b1) busy_low++;
    end
    total++; if (acks != 1) begin bad++; $display("FAIL held_ack_count: got %0d want 1", acks); end
    total++; if (busy_low != 0) begin bad++; $display("FAIL held_busy: got %0d idle cycles want 0", busy_low); end
    total++; if (bus0.mem_data_out !== D_MAIN) begin bad++; $display("FAIL held_dout_kept: got %h want %h", bus0.mem_data_out, D_MAIN); end
    drive(0, 1'b0, MEM_WRITE, 32'h0000_0100, 128'h1234);
    tick();
    total++; if (bus0.mem_busy !== 1'b0) begin bad++; $display("FAIL held_release: got %b want 0", bus0.mem_busy); end
    do_req(0, MEM_READ, 32'h0000_0100, '0, lat, rd, ex);
    total++; if (rd !== 128'h1234) begin bad++; $display("FAIL held_readback: got %h want 1234", rd); end
  endtask

  task automatic test_wrap();
    int lat, ex;
    logic [W-1:0] rd;
    do_req(0, MEM_WRITE, 32'h0001_0000, 128'h1, lat, rd, ex);
    do_req(0, MEM_READ, 32'h0000_0000, '0, lat, rd, ex);
    total++; if (rd !== 128'h1) begin bad++; $display("FAIL wrap_read: got %h want 1", rd); end
    do_req(0, MEM_READ, 32'h0000_004C, '0, lat, rd, ex);
    total++; if (rd !== D_MAIN) begin bad++; $display("FAIL low_bits_read: got %h want %h", rd, D_MAIN); end
  endtask

  task automatic test_mid_reset();
    int lat, ex;
    int acks = 0;
    logic [W-1:0] rd;
    do_req(0, MEM_WRITE, 32'h0000_0080, 128'hA5, lat, rd, ex);
    drive(0, 1'b1, MEM_WRITE, 32'h0000_0080, 128'hFF);
    tick();
    tick();
    tick();
    reset = 1'b0;
    drive(0, 1'b0, MEM_WRITE, 32'h0000_0080, 128'hFF);
    #1;
    total++; if (bus0.mem_busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", bus0.mem_busy); end
    total++; if (bus0.mem_data_out !== '0) begin bad++; $display("FAIL midrst_dout: got %h want 0", bus0.mem_data_out); end
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus0.mem_ack !== 1'b0) acks++;
    end
    total++; if (acks != 0) begin bad++; $display("FAIL midrst_no_ack: got %0d acks want 0", acks); end
    do_req(0, MEM_READ, 32'h0000_0080, '0, lat, rd, ex);
    total++; if (rd !== 128'hA5) begin bad++; $display("FAIL midrst_not_committed: got %h want a5", rd); end
  endtask

  task automatic test_input_change();
    int lat, ex;
    logic [W-1:0] rd;
    do_req(0, MEM_WRITE, 32'h0000_0200, 128'hCAFE, lat, rd, ex);
    do_req(0, MEM_WRITE, 32'h0000_0300, 128'hBEEF, lat, rd, ex);
    drive(0, 1'b1, MEM_READ, 32'h0000_0200, '0);
    tick();
    drive(0, 1'b1, MEM_WRITE, 32'h0000_0300, 128'h99);
    lat = -1;
    rd  = '0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus0.mem_ack === 1'b1) begin lat = i; rd = bus0.mem_data_out; break; end
    end
    drive(0, 1'b0, MEM_READ, 32'h0, '0);
    tick();
    tick();
    total++; if (lat != 5) begin bad++; $display("FAIL chg_latency: got %0d want 5", lat); end
    total++; if (rd !== 128'hCAFE) begin bad++; $display("FAIL chg_captured_addr: got %h want cafe", rd); end
    do_req(0, MEM_READ, 32'h0000_0300, '0, lat, rd, ex);
    total++; if (rd !== 128'hBEEF) begin bad++; $display("FAIL chg_captured_rw: got %h want beef", rd); end
  endtask

  task automatic test_latency1();
    int lat, ex;
    logic [W-1:0] rd;
    do_req(1, MEM_WRITE, 32'h0000_0040, 128'h77, lat, rd, ex);
    total++; if (lat != 1) begin bad++; $display("FAIL lat1_write: got %0d want 1", lat); end
    total++; if (ex != 0) begin bad++; $display("FAIL lat1_single_pulse: got %0d extra acks want 0", ex); end
    do_req(1, MEM_READ, 32'h0000_0040, '0, lat, rd, ex);
    total++; if (lat != 1) begin bad++; $display("FAIL lat1_read: got %0d want 1", lat); end
    total++; if (rd !== 128'h77) begin bad++; $display("FAIL lat1_data: got %h want 77", rd); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_held_enable();
    test_wrap();
    test_mid_reset();
    test_input_change();
    test_latency1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the CPU's single shared memory port, the far end of the arbiter's mem_enable/mem_rw/mem_ack handshake.
- Accepts one line-wide read or write request at a time.
- Completes each request after a fixed, programmable latency and acknowledges it with a one-cycle pulse.
- Used as the backing store for I-cache and D-cache refills and write-backs in simulation and synthesis.

Parameters:
- WIDTH, 128, line/data width in bits; must equal the cache line width `WIDTH.
- ADDR_W, 32, address width; must equal `ADDR_SIZE.
- DEPTH, 4096, number of lines stored; power of two.
- LATENCY, 5, cycles from request capture to mem_ack; LATENCY >= 1.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- mem_enable  input  1  request valid; the requester holds it high until it sees mem_ack.
- mem_rw  input  1  0 = read, 1 = write; sampled with the request.
- mem_addr  input  ADDR_W  byte address; low log2(WIDTH/8) bits ignored.
- mem_data_in  input  WIDTH  write data, sampled with the request.
- mem_data_out  output  WIDTH  read data; valid while mem_ack = 1.
- mem_ack  output  1  one-cycle completion pulse.
- mem_busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE, mem_ack = 0, mem_data_out = 0, latency counter = 0, mem_busy = 0.
  - Array contents are not cleared.
- Line index: mem_addr[log2(WIDTH/8) +: log2(DEPTH)]. Upper address bits are ignored, so addresses wrap modulo DEPTH lines.
- States: IDLE, BUSY, RESP, DROP.
- IDLE: at edge t0 with mem_enable = 1:
  - capture rw, index and write data into internal registers;
  - cnt = LATENCY-1; go to BUSY.
- BUSY:
  - If cnt != 0, decrement cnt.
  - If cnt == 0:
    - read: mem_data_out = array[index];
    - write: array[index] = captured data, and mem_data_out is unchanged;
    - mem_ack = 1; go to RESP.
  - mem_ack therefore rises at edge t0+LATENCY.
- RESP: at the next edge, mem_ack = 0. Go to IDLE if mem_enable = 0, otherwise to DROP.
- DROP: wait for mem_enable = 0, then go to IDLE. This prevents a still-high enable from being taken as a second request. A fresh request needs enable to go low for at least one sampled edge.
- Changes on the inputs after capture (t0) are ignored until the state returns to IDLE.
- mem_data_out holds its last read value until the next read completes. A write never changes it.
- Back-to-back: minimum spacing between request captures is LATENCY+2 edges (capture, LATENCY, DROP/IDLE).
- Reset mid-operation: the request is abandoned, mem_ack = 0, state = IDLE. A pending write is not committed.
- Read-after-write to the same line returns the new data, because the write commits at its ack edge.
- mem_enable = 0 in IDLE: no state change, no array access.

Decomposition:
- Shared define package (define.v) holds:
  - `WIDTH, `ADDR_SIZE;
  - MEM_READ = 1'b0, MEM_WRITE = 1'b1;
  - responder state encodings IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2, DROP = 2'd3.
- One sub-module, mem_line_array: synchronous single-port DEPTH x WIDTH storage. Ports: clk, we, index, wdata, and registered rdata. It has no reset and supports an optional $readmemh preload.
- The controller FSM and latency counter live in mem_responder.

Test Plan:
- Reset behaviour: hold reset = 0 for 3 cycles while mem_enable = 1 -> mem_ack = 0, mem_busy = 0, mem_data_out = 0 throughout; no request is captured.
- Write then read (LATENCY = 5):
  - Write 128'hDEADBEEF_00112233_44556677_8899AABB to addr 32'h0000_0040 with enable held high -> mem_ack is a single pulse exactly 5 edges after capture.
  - Then read the same addr -> mem_data_out equals the written value while mem_ack = 1.
- Held enable: keep mem_enable = 1 for 10 cycles after the ack -> exactly one ack, state stays in DROP, mem_busy = 1. After enable drops for one edge, mem_busy = 0.
- Wrap-around (DEPTH = 4096): write 128'h1 to addr 32'h0001_0000 -> a read of addr 32'h0 returns 128'h1. Low-bit variance: a read of 32'h0000_004C returns the same line as 32'h0000_0040.
- Mid-operation reset: write 128'hFF to addr 32'h80, then pulse reset low 2 edges after capture -> no ack is produced, and a later read of 32'h80 returns the prior contents (not 128'hFF).
- Input change after capture: change mem_addr and mem_rw during BUSY -> the response uses the captured address and direction.
- LATENCY = 1 configuration: mem_ack rises one edge after capture.
